rr_arbiter_burst: RTL

- Parametrised N-requester round-robin arbiter with packet lock and burst quota. It is the successor to the 2-input rr arbiter used at NoC router output ports.
- Grant is combinational, one-hot, and uses mask-based priority rotation.
- A winner may hold the grant across several consecutive updates, either while lock_i is high (multi-flit packet) or up to MAX_BURST updates. After that, priority rotates past it.
- One instance sits per router output port, ahead of the output mux.

---
 rtl/rr_arbiter_burst.sv | 103 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_burst.sv
// Round-robin arbiter with packet lock and burst quota for a NoC router output port.
// The one-hot grant is combinational from req_i; rotation state advances only on update_i.
module rr_arbiter_burst #(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 1
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic [N_REQ-1:0]         req_i,
   input  logic                     update_i,
   input  logic                     lock_i,
   output logic [N_REQ-1:0]         grant_o,
   output logic [$clog2(N_REQ)-1:0] grant_idx_o,
   output logic                     grant_valid_o
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] FIRST_CNT = (MAX_BURST > 1) ? CW'(1) : '0;

   logic [N_REQ-1:0] mask_q, mask_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic             hold_q, hold_d;
   logic [CW-1:0]    burst_cnt_q, burst_cnt_d;

   logic [N_REQ-1:0] masked_req;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic             owner_req;
   logic             new_owner;
   logic [CW-1:0]    cnt_eff;

   function automatic logic [IW-1:0] lowest(input logic [N_REQ-1:0] v);
      lowest = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (v[i]) lowest = IW'(i);
      end
   endfunction

   // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      masked_req = req_i & mask_q;
      owner_req  = req_i[owner_q];
      gnt_any    = |req_i;
      if (hold_q && owner_req) begin
         gnt_idx = owner_q;
      end else if (|masked_req) begin
         gnt_idx = lowest(masked_req);
      end else begin
         gnt_idx = lowest(req_i);
      end
      grant_o       = gnt_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
      grant_idx_o   = gnt_idx;
      grant_valid_o = gnt_any;
   end

   always_comb begin
      mask_d      = mask_q;
      owner_d     = owner_q;
      hold_d      = hold_q;
      burst_cnt_d = burst_cnt_q;
      // A winner that differs from the held owner starts a fresh quota.
      new_owner   = !hold_q || (gnt_idx != owner_q);
      cnt_eff     = new_owner ? '0 : burst_cnt_q;

      if (hold_q && !owner_req) hold_d = 1'b0;

      if (update_i && gnt_any) begin
         if (lock_i) begin
            owner_d     = gnt_idx;
            hold_d      = 1'b1;
            burst_cnt_d = new_owner ? FIRST_CNT : burst_cnt_q;
         end else if (int'(cnt_eff) + 1 < MAX_BURST) begin
            owner_d     = gnt_idx;
            hold_d      = 1'b1;
            burst_cnt_d = cnt_eff + CW'(1);
         end else begin
            hold_d      = 1'b0;
            burst_cnt_d = '0;
            for (int i = 0; i < N_REQ; i++) begin
               mask_d[i] = (i > int'(gnt_idx));
            end
            if (gnt_idx == IW'(N_REQ - 1)) mask_d = '1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         mask_q      <= '1;
         owner_q     <= '0;
         hold_q      <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         mask_q      <= mask_d;
         owner_q     <= owner_d;
         hold_q      <= hold_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule
